// File: rtl/bpu_pkg.sv
// Shared definitions for the next-PC prediction path: branch kinds,
// default widths and the default-width prediction metadata entry.
package bpu_pkg;

   localparam int unsigned BPU_ADDR_W = 30;
   localparam int unsigned BPU_GH_W   = 14;
   localparam int unsigned BPU_DEPTH  = 8;
   localparam int unsigned BPU_KIND_W = 3;

   typedef enum logic [BPU_KIND_W-1:0] {
      KIND_NOT_JUMP      = 3'd0,
      KIND_DIRECT_JUMP   = 3'd1,
      KIND_JUMP          = 3'd2,
      KIND_CALL          = 3'd3,
      KIND_RET           = 3'd4,
      KIND_INDIRECT_JUMP = 3'd5,
      KIND_OTHER_JUMP    = 3'd6
   } bpu_kind_e;

   typedef struct packed {
      logic [BPU_ADDR_W-1:0] pc;
      logic [BPU_GH_W-1:0]   gh_hashed;
      logic [BPU_ADDR_W-1:0] npc_pdc;
      logic [BPU_KIND_W-1:0] kind_pdc;
      logic                  taken_pdc;
      logic                  choice_pdc;
   } bpu_entry_t;

   function automatic logic is_ret(input logic [BPU_KIND_W-1:0] kind);
      return kind == 3'(KIND_RET);
   endfunction

endpackage

// File: rtl/bpu_meta_fifo.sv
// Circular buffer for prediction metadata with push, pop, flush and a
// combinational head read port; count separates full from empty.
module bpu_meta_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head_data_c,
   output logic [CNT_W-1:0] count,
   output logic             full_c,
   output logic             empty_c
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   assign head_data_c = mem[head];
   assign full_c      = (count == CNT_W'(DEPTH));
   assign empty_c     = (count == '0);

   // Storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[tail] <= din;
      end
   end

   // Flush retires the head and discards every younger entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= head + PTR_W'(1);
         tail  <= head + PTR_W'(1);
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/bpu_resolve_queue.sv
// Resolution end of next-PC prediction: queues fetch predictions in order,
// checks the oldest against the EX outcome, emits predictor update and redirect.
module bpu_resolve_queue
   import bpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = BPU_ADDR_W,
   parameter int unsigned gh_width   = BPU_GH_W,
   parameter int unsigned DEPTH      = BPU_DEPTH,
   localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enq_valid,
   output logic                  enq_ready,
   input  logic [ADDR_WIDTH-1:0] enq_pc,
   input  logic [gh_width-1:0]   enq_gh_hashed,
   input  logic [ADDR_WIDTH-1:0] enq_npc_pdc,
   input  logic [2:0]            enq_kind_pdc,
   input  logic                  enq_taken_pdc,
   input  logic                  enq_choice_pdc,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [ADDR_WIDTH-1:0] res_npc_real,
   input  logic [2:0]            res_kind_real,
   output logic                  update_en,
   output logic [ADDR_WIDTH-1:0] npc_ex,
   output logic [gh_width-1:0]   pc_ex_gh_hashed,
   output logic [2:0]            kind_ex,
   output logic                  choice_real,
   output logic                  mis_pdc,
   output logic                  redirect_valid,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [PTR_W:0]        occupancy,
   output logic                  underflow_err
);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [gh_width-1:0]   gh_hashed;
      logic [ADDR_WIDTH-1:0] npc_pdc;
      logic [2:0]            kind_pdc;
      logic                  taken_pdc;
      logic                  choice_pdc;
   } entry_t;

   localparam int unsigned ENTRY_W = $bits(entry_t);

   entry_t enq_entry_c;
   entry_t head_c;
   logic   full_c;
   logic   empty_c;
   logic   pop_c;
   logic   mis_c;
   logic   push_c;
   logic   choice_next_c;
   logic   unused_head_fields_c;

   assign enq_entry_c = '{
      pc:         enq_pc,
      gh_hashed:  enq_gh_hashed,
      npc_pdc:    enq_npc_pdc,
      kind_pdc:   enq_kind_pdc,
      taken_pdc:  enq_taken_pdc,
      choice_pdc: enq_choice_pdc
   };

   assign enq_ready = !full_c;
   assign res_ready = !empty_c;

   // A push alongside a mispredicting pop is wrong-path and is dropped.
   assign pop_c  = res_valid && res_ready;
   assign mis_c  = pop_c && (head_c.npc_pdc != res_npc_real);
   assign push_c = enq_valid && enq_ready && !mis_c;

   // Only a RET resolves through the chooser; a wrong RET means the other source was right.
   assign choice_next_c = is_ret(res_kind_real) ? (head_c.choice_pdc ^ mis_c)
                                                : head_c.choice_pdc;

   assign unused_head_fields_c = ^{head_c.pc, head_c.kind_pdc, head_c.taken_pdc};

   bpu_meta_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (push_c),
      .pop         (pop_c),
      .flush       (mis_c),
      .din         (enq_entry_c),
      .head_data_c (head_c),
      .count       (occupancy),
      .full_c      (full_c),
      .empty_c     (empty_c)
   );

   // Update bundle and redirect, one cycle after the resolving pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         update_en       <= 1'b0;
         npc_ex          <= '0;
         pc_ex_gh_hashed <= '0;
         kind_ex         <= '0;
         choice_real     <= 1'b0;
         mis_pdc         <= 1'b0;
         redirect_valid  <= 1'b0;
         redirect_pc     <= '0;
         underflow_err   <= 1'b0;
      end else begin
         update_en      <= pop_c;
         redirect_valid <= mis_c;
         if (pop_c) begin
            npc_ex          <= res_npc_real;
            pc_ex_gh_hashed <= head_c.gh_hashed;
            kind_ex         <= res_kind_real;
            choice_real     <= choice_next_c;
            mis_pdc         <= mis_c;
         end
         if (mis_c) begin
            redirect_pc <= res_npc_real;
         end
         if (res_valid && !res_ready) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bpu_resolve_queue.sv
// Bench for bpu_resolve_queue: directed vector table, full/wrap and reset
// sequences, and random traffic checked against a queue-based reference.
module tb_bpu_resolve_queue;

   localparam int unsigned AW    = 30;
   localparam int unsigned GW    = 14;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned PW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enq_valid = 1'b0;
   logic          enq_ready;
   logic [AW-1:0] enq_pc = '0;
   logic [GW-1:0] enq_gh_hashed = '0;
   logic [AW-1:0] enq_npc_pdc = '0;
   logic [2:0]    enq_kind_pdc = '0;
   logic          enq_taken_pdc = 1'b0;
   logic          enq_choice_pdc = 1'b0;
   logic          res_valid = 1'b0;
   logic          res_ready;
   logic [AW-1:0] res_npc_real = '0;
   logic [2:0]    res_kind_real = '0;
   logic          update_en;
   logic [AW-1:0] npc_ex;
   logic [GW-1:0] pc_ex_gh_hashed;
   logic [2:0]    kind_ex;
   logic          choice_real;
   logic          mis_pdc;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic [PW:0]   occupancy;
   logic          underflow_err;

   bpu_resolve_queue #(.ADDR_WIDTH(AW), .gh_width(GW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
      .enq_gh_hashed(enq_gh_hashed), .enq_npc_pdc(enq_npc_pdc),
      .enq_kind_pdc(enq_kind_pdc), .enq_taken_pdc(enq_taken_pdc),
      .enq_choice_pdc(enq_choice_pdc),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_npc_real(res_npc_real), .res_kind_real(res_kind_real),
      .update_en(update_en), .npc_ex(npc_ex), .pc_ex_gh_hashed(pc_ex_gh_hashed),
      .kind_ex(kind_ex), .choice_real(choice_real), .mis_pdc(mis_pdc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .occupancy(occupancy), .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: an ordered list of outstanding predictions.
   typedef struct {
      logic [AW-1:0] npc;
      logic [GW-1:0] gh;
      logic          ch;
   } ent_t;
   ent_t q[$];

   logic          m_upd, m_mis, m_red, m_ch, m_uf;
   logic [AW-1:0] m_npc, m_rpc;
   logic [GW-1:0] m_gh;
   logic [2:0]    m_kind;

   typedef struct {
      bit            ev;
      logic [AW-1:0] npc;
      bit            ch;
      bit            rv;
      logic [AW-1:0] rn;
      logic [2:0]    rk;
      bit            e_upd, e_mis, e_red, e_ch;
      int            e_occ;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_upd = 0; m_mis = 0; m_red = 0; m_ch = 0; m_uf = 0;
      m_npc = '0; m_rpc = '0; m_gh = '0; m_kind = '0;
   endtask

   // Drive one cycle, predict its effect from the queue rules, and compare.
   task automatic cycle(input bit ev, input logic [AW-1:0] pc, input logic [AW-1:0] npc,
                        input logic [GW-1:0] gh, input bit ch,
                        input bit rv, input logic [AW-1:0] rn, input logic [2:0] rk);
      bit   can_push, can_pop, push, pop, mis;
      ent_t h;
      enq_valid = ev; enq_pc = pc; enq_npc_pdc = npc; enq_gh_hashed = gh;
      enq_kind_pdc = 3'(pc % 7); enq_taken_pdc = pc[0]; enq_choice_pdc = ch;
      res_valid = rv; res_npc_real = rn; res_kind_real = rk;
      can_push = (q.size() != DEPTH);
      can_pop  = (q.size() != 0);
      chk("enq_ready", enq_ready, can_push);
      chk("res_ready", res_ready, can_pop);
      chk("occupancy_pre", occupancy, q.size());
      pop  = rv && can_pop;
      push = ev && can_push;
      mis  = 0;
      if (pop) begin
         h = q.pop_front();
         mis    = (h.npc != rn);
         m_npc  = rn; m_gh = h.gh; m_kind = rk; m_mis = mis;
         m_ch   = (rk == 3'd4 && mis) ? ~h.ch : h.ch;
         if (mis) begin
            q.delete();
            push  = 0;
            m_rpc = rn;
         end
      end
      if (rv && !can_pop) m_uf = 1;
      if (push) q.push_back('{npc: npc, gh: gh, ch: ch});
      m_upd = pop;
      m_red = pop && mis;
      step();
      chk("update_en", update_en, m_upd);
      chk("redirect_valid", redirect_valid, m_red);
      chk("npc_ex", npc_ex, m_npc);
      chk("pc_ex_gh_hashed", pc_ex_gh_hashed, m_gh);
      chk("kind_ex", kind_ex, m_kind);
      chk("choice_real", choice_real, m_ch);
      chk("mis_pdc", mis_pdc, m_mis);
      chk("redirect_pc", redirect_pc, m_rpc);
      chk("occupancy", occupancy, q.size());
      chk("underflow_err", underflow_err, m_uf);
   endtask

   function automatic vec_t mk(bit ev, logic [AW-1:0] npc, bit ch, bit rv,
                               logic [AW-1:0] rn, logic [2:0] rk,
                               bit e_upd, bit e_mis, bit e_red, bit e_ch, int e_occ);
      vec_t v;
      v.ev = ev; v.npc = npc; v.ch = ch; v.rv = rv; v.rn = rn; v.rk = rk;
      v.e_upd = e_upd; v.e_mis = e_mis; v.e_red = e_red; v.e_ch = e_ch; v.e_occ = e_occ;
      return v;
   endfunction

   function automatic logic [AW-1:0] head_npc();
      return (q.size() != 0) ? q[0].npc : '0;
   endfunction

   initial begin
      bit            ev, rv;
      logic [AW-1:0] rn;
      logic [2:0]    rk;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst update_en", update_en, 1'b0);
      chk("rst redirect_valid", redirect_valid, 1'b0);
      chk("rst occupancy", occupancy, 0);
      chk("rst enq_ready", enq_ready, 1'b1);
      chk("rst underflow_err", underflow_err, 1'b0);
      rst = 1'b0;

      // ev npc ch | rv rn rk | upd mis red choice occ
      tbl.push_back(mk(1, 30'h100, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 30'h200, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 2));
      tbl.push_back(mk(1, 30'h300, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 3));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h100, 3'd0, 1, 0, 0, 0, 2));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h200, 3'd1, 1, 0, 0, 0, 1));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h300, 3'd2, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 30'h554, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(1, 30'h600, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 2));
      tbl.push_back(mk(1, 30'h700, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 3));
      tbl.push_back(mk(1, 30'h800, 0, 0, 30'h0,   3'd0, 0, 0, 0, 0, 4));
      tbl.push_back(mk(1, 30'h900, 0, 1, 30'h555, 3'd1, 1, 1, 1, 0, 0));
      tbl.push_back(mk(0, 30'h0,   0, 0, 30'h0,   3'd0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 30'h40,  1, 0, 30'h0,   3'd0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h44,  3'd4, 1, 1, 1, 0, 0));
      tbl.push_back(mk(1, 30'h40,  1, 0, 30'h0,   3'd0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h40,  3'd4, 1, 0, 0, 1, 0));
      tbl.push_back(mk(1, 30'h40,  1, 0, 30'h0,   3'd0, 0, 0, 0, 1, 1));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h48,  3'd2, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 30'h0,   0, 1, 30'h0,   3'd0, 0, 1, 0, 1, 0));

      foreach (tbl[i]) begin
         cycle(tbl[i].ev, AW'(i), tbl[i].npc, GW'(tbl[i].npc), tbl[i].ch,
               tbl[i].rv, tbl[i].rn, tbl[i].rk);
         chk($sformatf("row%0d update_en", i), update_en, tbl[i].e_upd);
         chk($sformatf("row%0d mis_pdc", i), mis_pdc, tbl[i].e_mis);
         chk($sformatf("row%0d redirect_valid", i), redirect_valid, tbl[i].e_red);
         chk($sformatf("row%0d choice_real", i), choice_real, tbl[i].e_ch);
         chk($sformatf("row%0d occupancy", i), occupancy, tbl[i].e_occ);
         if (tbl[i].e_red) chk($sformatf("row%0d redirect_pc", i), redirect_pc, tbl[i].rn);
      end
      chk("underflow sticky", underflow_err, 1'b1);
      cycle(0, '0, '0, '0, 0, 0, '0, 3'd0);
      chk("underflow still set", underflow_err, 1'b1);

      // Fill to DEPTH, try a push while full, then free one slot.
      for (int i = 0; i < DEPTH; i++)
         cycle(1, AW'(i), AW'(32'h1000 + i * 16), GW'($urandom), 1'($urandom), 0, '0, 3'd0);
      chk("full enq_ready", enq_ready, 1'b0);
      chk("full occupancy", occupancy, 8);
      cycle(1, '0, 30'h3fff_ffff, GW'($urandom), 0, 0, '0, 3'd0);
      cycle(0, '0, '0, '0, 0, 1, head_npc(), 3'd1);
      chk("after pop enq_ready", enq_ready, 1'b1);
      chk("after pop occupancy", occupancy, 7);
      for (int i = 0; i < 20; i++)
         cycle(1, AW'(100 + i), AW'($urandom), GW'($urandom), 1'($urandom),
               (i % 2) == 1, head_npc(), 3'(i % 7));
      for (int i = 0; i < 16 && q.size() != 0; i++)
         cycle(0, '0, '0, '0, 0, 1, head_npc(), 3'd0);
      chk("drained occupancy", occupancy, 0);

      // Random traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         ev = ($urandom % 5) < 3;
         rv = ($urandom % 2) == 1;
         rn = (q.size() != 0 && ($urandom % 4) != 0) ? q[0].npc : AW'($urandom);
         rk = ($urandom % 2) ? 3'd4 : 3'($urandom % 7);
         cycle(ev, AW'($urandom), AW'($urandom), GW'($urandom), 1'($urandom), rv, rn, rk);
      end

      // Reset while holding five entries with a pop in flight.
      for (int i = 0; i < 16 && q.size() != 0; i++)
         cycle(0, '0, '0, '0, 0, 1, head_npc(), 3'd0);
      for (int i = 0; i < 6; i++)
         cycle(1, AW'(i), AW'(32'h2000 + i), GW'(i + 1), 0, 0, '0, 3'd0);
      cycle(0, '0, '0, '0, 0, 1, head_npc(), 3'd0);
      chk("pre-reset occupancy", occupancy, 5);
      chk("pre-reset update_en", update_en, 1'b1);
      res_npc_real = head_npc();
      #2 rst = 1'b1;
      #1;
      chk("async rst update_en", update_en, 1'b0);
      chk("async rst redirect_valid", redirect_valid, 1'b0);
      chk("async rst occupancy", occupancy, 0);
      chk("async rst enq_ready", enq_ready, 1'b1);
      chk("async rst npc_ex", npc_ex, 0);
      chk("async rst underflow_err", underflow_err, 1'b0);
      model_reset();
      step();
      enq_valid = 0; res_valid = 0;
      rst = 1'b0;
      cycle(0, '0, '0, '0, 0, 0, '0, 3'd0);
      cycle(0, '0, '0, '0, 0, 0, '0, 3'd0);
      chk("post-reset update_en", update_en, 1'b0);
      chk("post-reset redirect_valid", redirect_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
